// File: rtl/mac_seq_ctrl_if.sv
// Host, operand-memory and MAC signals of the dot-product sequencer.
// master is the sequencer's view; slave is the surrounding host/memory/MAC.
interface mac_seq_ctrl_if #(
  parameter int ADDR_W = 4
) ();
  logic                     start;
  logic [ADDR_W:0]          len;
  logic                     busy;
  logic                     done;
  logic                     err;
  logic signed [15:0]       result;
  logic                     result_ovf;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [7:0]        a_data;
  logic signed [7:0]        b_data;
  logic                     mac_reset;
  logic                     mac_valid_in;
  logic signed [7:0]        mac_a;
  logic signed [7:0]        mac_b;
  logic signed [15:0]       mac_f;
  logic                     mac_overflow;
  logic                     mac_valid_out;

  modport master (
    input  start, len, a_data, b_data, mac_f, mac_overflow, mac_valid_out,
    output busy, done, err, result, result_ovf, rd_en, rd_addr,
           mac_reset, mac_valid_in, mac_a, mac_b
  );

  modport slave (
    output start, len, a_data, b_data, mac_f, mac_overflow, mac_valid_out,
    input  busy, done, err, result, result_ovf, rd_en, rd_addr,
           mac_reset, mac_valid_in, mac_a, mac_b
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer for a signed 8x8 MAC: clear, stream LEN operand pairs, collect result.
// First read 2 cycles after start, done 1 cycle after final return; no backpressure, watchdog aborts a stalled MAC.
module mac_seq_ctrl #(
  parameter int ADDR_W = 4,
  parameter int WDOG   = 16
) (
  input  logic           clk,
  input  logic           reset,
  mac_seq_ctrl_if.master bus
);
  localparam int WD_W = $clog2(WDOG + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [ADDR_W:0]    r_len;
  logic [ADDR_W:0]    r_ret_cnt;
  logic [ADDR_W-1:0]  r_rd_addr;
  logic               r_rd_en;
  logic               r_mac_vin;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               r_ovf;
  logic signed [15:0] r_result;
  logic [WD_W-1:0]    r_wdog;

  logic               w_ret;
  logic [ADDR_W:0]    w_ret_next;
  logic               w_last_addr;

  // Returns only count while operands are in flight; strays elsewhere are dropped.
  assign w_ret       = bus.mac_valid_out && (r_state == S_FETCH || r_state == S_DRAIN);
  assign w_ret_next  = r_ret_cnt + (ADDR_W+1)'(1);
  assign w_last_addr = ({1'b0, r_rd_addr} == r_len - (ADDR_W+1)'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_ret_cnt <= '0;
      r_rd_addr <= '0;
      r_rd_en   <= 1'b0;
      r_mac_vin <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_ovf     <= 1'b0;
      r_result  <= '0;
      r_wdog    <= '0;
    end else begin
      r_mac_vin <= r_rd_en;
      if (w_ret) begin
        r_ret_cnt <= w_ret_next;
        r_ovf     <= r_ovf | bus.mac_overflow;
      end
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (bus.start) begin
            r_len     <= bus.len;
            r_ovf     <= 1'b0;
            r_ret_cnt <= '0;
            r_wdog    <= '0;
            r_result  <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (r_len == '0) begin
            r_result <= '0;
            r_err    <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
            r_state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_wdog <= '0;
          if (w_last_addr) begin
            r_rd_en <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_rd_addr <= r_rd_addr + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (w_ret && w_ret_next == r_len) begin
            r_result <= bus.mac_f;
            r_err    <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else if (w_ret) begin
            r_wdog <= '0;
          end else if (r_wdog == WD_W'(WDOG - 1)) begin
            // Watchdog: capture whatever the MAC holds and report the abort.
            r_result <= bus.mac_f;
            r_err    <= 1'b1;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.err          = r_err;
  assign bus.result       = r_result;
  assign bus.result_ovf   = r_ovf;
  assign bus.rd_en        = r_rd_en;
  assign bus.rd_addr      = r_rd_addr;
  assign bus.mac_reset    = reset || (r_state == S_CLEAR);
  assign bus.mac_valid_in = r_mac_vin;
  assign bus.mac_a        = r_mac_vin ? bus.a_data : 8'sd0;
  assign bus.mac_b        = r_mac_vin ? bus.b_data : 8'sd0;
endmodule
